mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory access and write-back.
- Drives the select lines of the PC selecter mux, the register file, the ALU operand muxes and the memory strobes.
- Sits between the instruction register opcode field / ALU zero flag and every datapath control input; stalls on a memory ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-if-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag, combinational from the current ALU operation
- mem_ready  in  1  memory completes the access this cycle
- pc_write  out  1  PC register load enable (already qualified by zero for beq)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load enable
- mem_to_reg  out  1  register write data select: 1 = MDR
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct field decides
- pc_source  out  2  00 = ALU result (PC+4), 01 = ALUOut (branch target), 10 = jump target; 11 never driven
- illegal_op  out  1  sticky flag: unknown opcode decoded
- busy  out  1  high in every state except INIT

Behaviour:
- States: INIT, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- Reset (rst_n=0, asynchronous): state = INIT; all outputs 0; illegal_op cleared. INIT → FETCH unconditionally on the next edge.
- Outputs are Moore decode of the state, except pc_write in FETCH and BRANCH. Any output not listed for a state is 0.
- FETCH: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Hold FETCH while mem_ready=0; on mem_ready=1 → DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - LW/SW → MEM_ADDR
  - RTYPE → R_EXEC
  - ADDI → I_EXEC
  - BEQ → BRANCH
  - J → JUMP
  - any other opcode → set illegal_op, then FETCH (instruction treated as NOP; PC already advanced).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. LW → MEM_RD; SW → MEM_WR (opcode still held by IR).
- MEM_RD: i_or_d=1, mem_read=1; hold until mem_ready=1, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WR: i_or_d=1, mem_write=1; hold until mem_ready=1, then → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 → I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=zero → FETCH.
- JUMP: pc_source=10, pc_write=1 → FETCH.
- Stall rule: while waiting on mem_ready, all outputs are held constant; ir_write and pc_write are never asserted during a stall cycle.
- Latency with mem_ready tied high: lw 5 cycles; sw, R-type, addi 4; beq, j 3.
- illegal_op stays set until reset.
- Reset mid-instruction aborts immediately; no partial write strobe survives the reset edge.
- busy=0 only in INIT.

Test Plan:
- Reset asserted mid-MEM_WR, then released → mem_write drops asynchronously; 1 cycle of INIT (all outputs 0, busy=0); FETCH next with mem_read=1, pc_source=00.
- mem_ready=1 always, opcode=OP_LW → state sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; reg_write=1 and mem_to_reg=1 only in cycle 5; back in FETCH at cycle 6.
- opcode=OP_BEQ, zero=1 then zero=0 → BRANCH drives pc_source=01 in both runs; pc_write=1 only with zero=1; each instruction takes 3 cycles.
- opcode=OP_J → JUMP cycle has pc_source=10 and pc_write=1; pc_source is never 11 across a random opcode run of 1000 instructions.
- mem_ready low for 3 cycles in FETCH and again in MEM_RD → outputs stable; ir_write/pc_write asserted exactly once, on the ready cycle; lw total = 11 cycles.
- opcode=6'b111111 → illegal_op rises after DECODE and stays 1; FETCH follows with no reg_write or mem_write issued.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Main control FSM for the multicycle MIPS datapath. Sequences
//            fetch, decode, execute, memory access and write-back, and drives
//            every datapath select / strobe. Stalls on the memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_R_EXEC   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_I_EXEC   = 4'd9,
    ST_I_WB     = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12
  } state_t;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       opcode_known;

  // Moore outputs are registered: each flop holds the decode of the state
  // currently occupied, so it is computed from the next state.
  logic       pc_write_q,   pc_write_d;   // unconditional part (JUMP)
  logic       i_or_d_q,     i_or_d_d;
  logic       mem_read_q,   mem_read_d;
  logic       mem_write_q,  mem_write_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic       reg_dst_q,    reg_dst_d;
  logic       reg_write_q,  reg_write_d;
  logic       alu_src_a_q,  alu_src_a_d;
  logic [1:0] alu_src_b_q,  alu_src_b_d;
  logic [1:0] alu_op_q,     alu_op_d;
  logic [1:0] pc_source_q,  pc_source_d;
  logic       busy_q,       busy_d;

  assign opcode_known = (opcode == OP_RTYPE) || (opcode == OP_LW) ||
                        (opcode == OP_SW)    || (opcode == OP_BEQ) ||
                        (opcode == OP_J)     || (opcode == OP_ADDI);

  // Next-state sequencing and sticky illegal-opcode capture
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_INIT:     state_d = ST_FETCH;
      ST_FETCH:    state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = ST_MEM_ADDR;
        else if (opcode == OP_RTYPE)                state_d = ST_R_EXEC;
        else if (opcode == OP_ADDI)                 state_d = ST_I_EXEC;
        else if (opcode == OP_BEQ)                  state_d = ST_BRANCH;
        else if (opcode == OP_J)                    state_d = ST_JUMP;
        else                                        state_d = ST_FETCH;
        if (!opcode_known) illegal_d = 1'b1;
      end
      ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   state_d = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   state_d = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_R_EXEC:   state_d = ST_R_WB;
      ST_R_WB:     state_d = ST_FETCH;
      ST_I_EXEC:   state_d = ST_I_WB;
      ST_I_WB:     state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      default:     state_d = ST_INIT;
    endcase
  end

  // Moore output decode of the state about to be entered
  always_comb begin
    pc_write_d   = 1'b0;
    i_or_d_d     = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_dst_d    = 1'b0;
    reg_write_d  = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 2'b00;
    alu_op_d     = 2'b00;
    pc_source_d  = 2'b00;
    busy_d       = (state_d != ST_INIT);
    case (state_d)
      ST_FETCH: begin
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
      end
      ST_DECODE:   alu_src_b_d = 2'b11;
      ST_MEM_ADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      ST_MEM_RD: begin
        i_or_d_d   = 1'b1;
        mem_read_d = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      ST_MEM_WR: begin
        i_or_d_d    = 1'b1;
        mem_write_d = 1'b1;
      end
      ST_R_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = 2'b10;
      end
      ST_R_WB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      ST_I_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      ST_I_WB:     reg_write_d = 1'b1;
      ST_BRANCH: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = 2'b01;
        pc_source_d = 2'b01;
      end
      ST_JUMP: begin
        pc_source_d = 2'b10;
        pc_write_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, sticky flag and registered outputs; async reset aborts any strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      illegal_q    <= 1'b0;
      pc_write_q   <= 1'b0;
      i_or_d_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_dst_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= 2'b00;
      alu_op_q     <= 2'b00;
      pc_source_q  <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_q    <= illegal_d;
      pc_write_q   <= pc_write_d;
      i_or_d_q     <= i_or_d_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_dst_q    <= reg_dst_d;
      reg_write_q  <= reg_write_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_op_q     <= alu_op_d;
      pc_source_q  <= pc_source_d;
      busy_q       <= busy_d;
    end
  end

  // Load enables that depend on same-cycle inputs: never high while stalled
  assign ir_write   = (state_q == ST_FETCH) && mem_ready;
  assign pc_write   = pc_write_q ||
                      ((state_q == ST_FETCH)  && mem_ready) ||
                      ((state_q == ST_BRANCH) && zero);

  assign i_or_d     = i_or_d_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_to_reg = mem_to_reg_q;
  assign reg_dst    = reg_dst_q;
  assign reg_write  = reg_write_q;
  assign alu_src_a  = alu_src_a_q;
  assign alu_src_b  = alu_src_b_q;
  assign alu_op     = alu_op_q;
  assign pc_source  = pc_source_q;
  assign illegal_op = illegal_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Brief    : Directed self-checking bench for the multicycle MIPS control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_BAD   = 6'b111111;

  localparam int S_INIT = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3,
                 S_MEM_RD = 4, S_MEM_WB = 5, S_MEM_WR = 6, S_R_EXEC = 7,
                 S_R_WB = 8, S_I_EXEC = 9, S_I_WB = 10, S_BRANCH = 11,
                 S_JUMP = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, illegal_op, busy;
  logic [1:0] alu_src_b, alu_op, pc_source;

  int n_vec = 0;
  int n_err = 0;
  int cycles;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .busy(busy)
  );

  // {busy,pc_write,ir_write,i_or_d,mem_read,mem_write,mem_to_reg,reg_dst,
  //  reg_write,alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_source[1:0]}
  wire [15:0] out_vec = {busy, pc_write, ir_write, i_or_d, mem_read, mem_write,
                         mem_to_reg, reg_dst, reg_write, alu_src_a,
                         alu_src_b, alu_op, pc_source};

  // Expected output vector for a state, straight from the state table
  function automatic logic [15:0] exp_vec(input int st, input logic rdy, input logic z);
    case (st)
      S_INIT:     return 16'b0_0_0_0_0_0_0_0_0_0_00_00_00;
      S_FETCH:    return {1'b1, rdy, rdy, 13'b0_1_0_0_0_0_0_01_00_00};
      S_DECODE:   return 16'b1_0_0_0_0_0_0_0_0_0_11_00_00;
      S_MEM_ADDR: return 16'b1_0_0_0_0_0_0_0_0_1_10_00_00;
      S_MEM_RD:   return 16'b1_0_0_1_1_0_0_0_0_0_00_00_00;
      S_MEM_WB:   return 16'b1_0_0_0_0_0_1_0_1_0_00_00_00;
      S_MEM_WR:   return 16'b1_0_0_1_0_1_0_0_0_0_00_00_00;
      S_R_EXEC:   return 16'b1_0_0_0_0_0_0_0_0_1_00_10_00;
      S_R_WB:     return 16'b1_0_0_0_0_0_0_1_1_0_00_00_00;
      S_I_EXEC:   return 16'b1_0_0_0_0_0_0_0_0_1_10_00_00;
      S_I_WB:     return 16'b1_0_0_0_0_0_0_0_1_0_00_00_00;
      S_BRANCH:   return {1'b1, z, 14'b0_0_0_0_0_0_0_1_00_01_01};
      S_JUMP:     return 16'b1_1_0_0_0_0_0_0_0_0_00_00_10;
      default:    return 16'hffff;
    endcase
  endfunction

  // Count one comparison and report it when it misses
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for one cycle, check outputs mid-cycle, advance to next negedge
  task automatic step(input string tag, input int st, input logic rdy, input logic z);
    mem_ready = rdy;
    zero      = z;
    #1;
    chk($sformatf("%s_st%0d", tag, st), {16'd0, out_vec}, {16'd0, exp_vec(st, rdy, z)});
    chk($sformatf("%s_pcsrc", tag), {31'd0, pc_source == 2'b11}, 32'd0);
    cycles++;
    @(negedge clk);
  endtask

  // Execute one instruction with optional stalls in FETCH and in the memory state
  task automatic run_op(input string tag, input logic [5:0] op, input logic z,
                        input int fs, input int ms, input int exp_lat);
    cycles = 0;
    opcode = op;
    for (int i = 0; i < fs; i++) step(tag, S_FETCH, 1'b0, z);
    step(tag, S_FETCH, 1'b1, z);
    step(tag, S_DECODE, 1'b1, z);
    case (op)
      C_OP_LW: begin
        step(tag, S_MEM_ADDR, 1'b1, z);
        for (int i = 0; i < ms; i++) step(tag, S_MEM_RD, 1'b0, z);
        step(tag, S_MEM_RD, 1'b1, z);
        step(tag, S_MEM_WB, 1'b1, z);
      end
      C_OP_SW: begin
        step(tag, S_MEM_ADDR, 1'b1, z);
        for (int i = 0; i < ms; i++) step(tag, S_MEM_WR, 1'b0, z);
        step(tag, S_MEM_WR, 1'b1, z);
      end
      C_OP_RTYPE: begin
        step(tag, S_R_EXEC, 1'b1, z);
        step(tag, S_R_WB, 1'b1, z);
      end
      C_OP_ADDI: begin
        step(tag, S_I_EXEC, 1'b1, z);
        step(tag, S_I_WB, 1'b1, z);
      end
      C_OP_BEQ: step(tag, S_BRANCH, 1'b1, z);
      C_OP_J:   step(tag, S_JUMP, 1'b1, z);
      default: ;
    endcase
    chk({tag, "_latency"}, cycles, exp_lat);
  endtask

  function automatic int lat_of(input logic [5:0] op);
    case (op)
      C_OP_LW:                        return 5;
      C_OP_SW, C_OP_RTYPE, C_OP_ADDI: return 4;
      C_OP_BEQ, C_OP_J:               return 3;
      default:                        return 2;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ops [7];
    logic [5:0] rop;
    logic       rz;
    ops = '{C_OP_RTYPE, C_OP_LW, C_OP_SW, C_OP_BEQ, C_OP_J, C_OP_ADDI, C_OP_BAD};

    // Power-on reset
    @(negedge clk);
    #1;
    chk("reset_outputs", {16'd0, out_vec}, 32'd0);
    chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    step("init", S_INIT, 1'b1, 1'b0);

    // Directed instructions, mem_ready tied high
    run_op("lw",   C_OP_LW,    1'b0, 0, 0, 5);
    run_op("sw",   C_OP_SW,    1'b0, 0, 0, 4);
    run_op("rtyp", C_OP_RTYPE, 1'b0, 0, 0, 4);
    run_op("addi", C_OP_ADDI,  1'b0, 0, 0, 4);
    run_op("beq1", C_OP_BEQ,   1'b1, 0, 0, 3);
    run_op("beq0", C_OP_BEQ,   1'b0, 0, 0, 3);
    run_op("j",    C_OP_J,     1'b0, 0, 0, 3);

    // Stalls: 3 cycles in FETCH and 3 in MEM_RD gives 11 cycles
    run_op("lw_stall", C_OP_LW, 1'b0, 3, 3, 11);
    run_op("sw_stall", C_OP_SW, 1'b0, 2, 2, 8);

    // Illegal opcode: flag rises after DECODE and sticks
    chk("illegal_before", {31'd0, illegal_op}, 32'd0);
    run_op("bad", C_OP_BAD, 1'b0, 0, 0, 2);
    chk("illegal_set", {31'd0, illegal_op}, 32'd1);
    run_op("after_bad", C_OP_RTYPE, 1'b0, 0, 0, 4);
    chk("illegal_sticky", {31'd0, illegal_op}, 32'd1);

    // Random opcode run
    for (int k = 0; k < 1000; k++) begin
      rop = ops[$urandom_range(0, 6)];
      rz  = 1'($urandom_range(0, 1));
      run_op("rnd", rop, rz, 0, 0, lat_of(rop));
    end
    chk("illegal_sticky_end", {31'd0, illegal_op}, 32'd1);

    // Reset asserted mid-MEM_WR
    cycles = 0;
    opcode = C_OP_SW;
    step("rst_sw", S_FETCH, 1'b1, 1'b0);
    step("rst_sw", S_DECODE, 1'b1, 1'b0);
    step("rst_sw", S_MEM_ADDR, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("midwr_mem_write", {31'd0, mem_write}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midwr_async_drop", {31'd0, mem_write}, 32'd0);
    chk("midwr_all_zero", {16'd0, out_vec}, 32'd0);
    chk("midwr_illegal_clr", {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_init", S_INIT, 1'b1, 1'b0);
    step("rst_fetch", S_FETCH, 1'b1, 1'b0);
    chk("post_rst_decode_busy", {31'd0, busy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
